audio_pwm_driver: RTL and testbench

Consumes the N-bit sample stream `dacCount` from sound_generator and drives a single-bit PWM audio pin for the board speaker.
- The PWM period is 2^N clocks; the duty is re-latched once per period.
- Duty is scaled by a 2-bit volume control.
- A per-period gain ramp fades the sound in and out, so enable/disable produces no click.

---
 rtl/sound_pkg.sv | 24 ++
 rtl/audio_pwm_driver_if.sv | 21 ++
 rtl/pwm_period_counter.sv | 24 ++
 rtl/audio_pwm_driver.sv | 101 ++++++++++
 tb/tb_audio_pwm_driver.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared types and volume encoding for the audio PWM path.
package sound_pkg;

    typedef enum logic [1:0] {IDLE, RAMP_UP, PLAY, RAMP_DOWN} ramp_state_t;

    localparam logic [1:0] VolFull    = 2'd3;
    localparam logic [1:0] VolHalf    = 2'd2;
    localparam logic [1:0] VolQuarter = 2'd1;
    localparam logic [1:0] VolEighth  = 2'd0;

    // Right-shift applied to the sample for a given volume code.
    function automatic logic [1:0] vol_shift(input logic [1:0] volume);
        logic [1:0] sh;
        sh = 2'd3;
        unique case (volume)
            VolFull:    sh = 2'd0;
            VolHalf:    sh = 2'd1;
            VolQuarter: sh = 2'd2;
            VolEighth:  sh = 2'd3;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/audio_pwm_driver_if.sv
// Sample/control inputs and PWM/status outputs of the audio PWM driver.
interface audio_pwm_driver_if #(
    parameter int unsigned N = 7
);
    logic         enable;
    logic [N-1:0] dacCount;
    logic [1:0]   volume;
    logic         pwmOut;
    logic         busy;
    logic         periodTick;

    modport master (
        output enable, dacCount, volume,
        input  pwmOut, busy, periodTick
    );

    modport slave (
        input  enable, dacCount, volume,
        output pwmOut, busy, periodTick
    );
endinterface

// File: rtl/pwm_period_counter.sv
// Free-running N-bit PWM period counter; periodTick flags the last cycle of each period.
module pwm_period_counter #(
    parameter int unsigned N = 7
) (
    input  logic         clk,
    input  logic         nRst,
    output logic [N-1:0] cnt,
    output logic         periodTick
);

    logic [N-1:0] cnt_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + {{(N-1){1'b0}}, 1'b1};
        end
    end

    assign cnt        = cnt_q;
    assign periodTick = (cnt_q == {N{1'b1}});

endmodule

// File: rtl/audio_pwm_driver.sv
// Single-pin PWM audio driver with volume scaling and a per-period fade in/out gain ramp.
module audio_pwm_driver
    import sound_pkg::*;
#(
    parameter int unsigned N          = 7,
    parameter int unsigned RAMP_SHIFT = 2
) (
    input logic               clk,
    input logic               nRst,
    audio_pwm_driver_if.slave bus
);

    localparam int unsigned GW = RAMP_SHIFT + 1;
    localparam int unsigned PW = N + RAMP_SHIFT + 1;
    localparam logic [GW-1:0] GainOne = GW'(1);
    localparam logic [GW-1:0] GainMax = GW'(1 << RAMP_SHIFT);

    logic [N-1:0]  cnt;
    logic          period_tick;
    ramp_state_t   state_q, state_d;
    logic [GW-1:0] gain_q, gain_d, gain_up, gain_dn;
    logic [N-1:0]  duty_q, duty_d, vs;
    logic [PW-1:0] prod;
    logic          busy_q, pwm_q;

    pwm_period_counter #(
        .N(N)
    ) u_counter (
        .clk        (clk),
        .nRst       (nRst),
        .cnt        (cnt),
        .periodTick (period_tick)
    );

    assign gain_up = gain_q + GainOne;
    assign gain_dn = gain_q - GainOne;

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = RAMP_UP;
                    gain_d  = GainOne;
                end else begin
                    gain_d = '0;
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (bus.enable) begin
                    gain_d  = gain_up;
                    state_d = (gain_up == GainMax) ? PLAY : RAMP_UP;
                end else begin
                    gain_d  = gain_dn;
                    state_d = (gain_dn == '0) ? IDLE : RAMP_DOWN;
                end
            end
            PLAY: begin
                if (!bus.enable) begin
                    gain_d  = gain_dn;
                    state_d = (gain_dn == '0) ? IDLE : RAMP_DOWN;
                end
            end
            default: begin
                state_d = IDLE;
                gain_d  = '0;
            end
        endcase
    end

    // Duty uses the post-update gain so the new level takes effect in the very next period.
    always_comb begin
        vs     = bus.dacCount >> vol_shift(bus.volume);
        prod   = PW'(vs) * PW'(gain_d);
        duty_d = N'(prod >> RAMP_SHIFT);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            gain_q  <= '0;
            duty_q  <= '0;
            busy_q  <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_q <= (cnt < duty_q);
            if (period_tick) begin
                state_q <= state_d;
                gain_q  <= gain_d;
                duty_q  <= duty_d;
                busy_q  <= (state_d != IDLE);
            end
        end
    end

    assign bus.pwmOut     = pwm_q;
    assign bus.busy       = busy_q;
    assign bus.periodTick = period_tick;

endmodule

// File: tb/tb_audio_pwm_driver.sv
// Self-checking bench for audio_pwm_driver: directed scenarios plus randomized periods vs a gain model.
module tb_audio_pwm_driver;

    localparam int N      = 7;
    localparam int RS     = 2;
    localparam int PERIOD = 1 << N;
    localparam int GMAX   = 1 << RS;

    logic clk = 1'b0;
    logic nRst;

    audio_pwm_driver_if #(.N(N)) bus ();

    audio_pwm_driver #(
        .N          (N),
        .RAMP_SHIFT (RS)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: gain saturates in 0..GMAX, moving one step per tick toward enable.
    int m_gain   = 0;
    int exp_duty = 0;
    bit exp_busy = 1'b0;

    function automatic void model_step(input bit en, input int dac, input int vol);
        if (en) m_gain = (m_gain < GMAX) ? m_gain + 1 : GMAX;
        else    m_gain = (m_gain > 0) ? m_gain - 1 : 0;
        exp_duty = ((dac >> (3 - vol)) * m_gain) / GMAX;
        exp_busy = (m_gain != 0);
    endfunction

    // Drives inputs for one tick, then measures the following period.
    // high counts cycles cnt=0..126 (cnt=127 can never be high); edge_s is the cnt=127 sample
    // of the previous period.
    task automatic run_period(input bit en, input int dac, input int vol,
                              output int high, output logic busy_s, output logic edge_s);
        int guard = 0;
        while (bus.periodTick !== 1'b1 && guard < 2 * PERIOD) begin
            @(negedge clk);
            guard++;
        end
        if (bus.periodTick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: periodTick=%b required 1", bus.periodTick);
        end
        bus.enable   = en;
        bus.dacCount = dac[N-1:0];
        bus.volume   = vol[1:0];
        model_step(en, dac, vol);
        high   = 0;
        busy_s = 1'bx;
        edge_s = 1'bx;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (i == 0) begin
                busy_s = bus.busy;
                edge_s = bus.pwmOut;
            end else if (bus.pwmOut === 1'b1) begin
                high++;
            end
            if (i == PERIOD / 2) begin
                bus.enable   = 1'($urandom_range(0, 1));
                bus.dacCount = N'($urandom);
                bus.volume   = 2'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        int n = 0;
        bus.enable   = 1'b1;
        bus.dacCount = 7'd127;
        bus.volume   = 2'd3;
        nRst         = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.pwmOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_pwm: got %b required 0", bus.pwmOut);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b required 0", bus.busy);
        end
        checks++;
        if (bus.periodTick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b required 0", bus.periodTick);
        end
        nRst       = 1'b1;
        bus.enable = 1'b0;
        m_gain     = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.periodTick !== 1'b1 && n < 2 * PERIOD);
        checks++;
        if (n != PERIOD - 1) begin
            errors++;
            $display("FAIL first_tick: got %0d cycles required %0d", n, PERIOD - 1);
        end
    endtask

    task automatic test_fade_in();
        int req[6] = '{25, 50, 75, 100, 100, 100};
        int h;
        logic b, e;
        for (int p = 0; p < 6; p++) begin
            run_period(1'b1, 100, 3, h, b, e);
            checks++;
            if (h != req[p]) begin
                errors++;
                $display("FAIL fade_in_duty[%0d]: got %0d required %0d", p, h, req[p]);
            end
            checks++;
            if (b !== 1'b1) begin
                errors++;
                $display("FAIL fade_in_busy[%0d]: got %b required 1", p, b);
            end
        end
    endtask

    task automatic test_volume();
        int vols[3] = '{1, 0, 2};
        int req[3]  = '{25, 12, 50};
        int h;
        logic b, e;
        for (int p = 0; p < 3; p++) begin
            run_period(1'b1, 100, vols[p], h, b, e);
            checks++;
            if (h != req[p]) begin
                errors++;
                $display("FAIL volume[%0d]: got %0d required %0d", vols[p], h, req[p]);
            end
        end
    endtask

    task automatic test_extremes();
        int h;
        logic b, e;
        run_period(1'b1, 127, 3, h, b, e);
        checks++;
        if (h != 127) begin
            errors++;
            $display("FAIL max_duty: got %0d required 127", h);
        end
        run_period(1'b1, 0, 3, h, b, e);
        checks++;
        if (h != 0) begin
            errors++;
            $display("FAIL zero_duty: got %0d required 0", h);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL max_duty_last_cycle: got %b required 0", e);
        end
    endtask

    task automatic test_fade_out();
        bit en_seq[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int req[8]    = '{75, 50, 75, 100, 75, 50, 25, 0};
        bit breq[8]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int h;
        logic b, e;
        run_period(1'b1, 100, 3, h, b, e);
        for (int p = 0; p < 8; p++) begin
            run_period(en_seq[p], 100, 3, h, b, e);
            checks++;
            if (h != req[p]) begin
                errors++;
                $display("FAIL fade_out_duty[%0d]: got %0d required %0d", p, h, req[p]);
            end
            checks++;
            if (b !== breq[p]) begin
                errors++;
                $display("FAIL fade_out_busy[%0d]: got %b required %b", p, b, breq[p]);
            end
        end
    endtask

    task automatic test_async_reset();
        int h;
        logic b, e;
        for (int p = 0; p < 5; p++) run_period(1'b1, 127, 3, h, b, e);
        checks++;
        if (bus.pwmOut !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pwm: got %b required 1", bus.pwmOut);
        end
        #2 nRst = 1'b0;
        #1;
        checks++;
        if (bus.pwmOut !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_pwm: got %b required 0", bus.pwmOut);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_busy: got %b required 0", bus.busy);
        end
        @(negedge clk);
        nRst       = 1'b1;
        bus.enable = 1'b0;
        m_gain     = 0;
        run_period(1'b0, 100, 3, h, b, e);
        checks++;
        if (h != 0 || b !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got duty=%0d busy=%b required duty=0 busy=0", h, b);
        end
        run_period(1'b1, 100, 3, h, b, e);
        checks++;
        if (h != 25) begin
            errors++;
            $display("FAIL post_reset_ramp: got %0d required 25", h);
        end
    endtask

    task automatic test_random();
        int h, dac, vol;
        bit en;
        logic b, e;
        for (int p = 0; p < 30; p++) begin
            en  = ($urandom_range(0, 3) != 0);
            dac = $urandom_range(0, PERIOD - 1);
            vol = $urandom_range(0, 3);
            run_period(en, dac, vol, h, b, e);
            checks++;
            if (h != exp_duty) begin
                errors++;
                $display("FAIL rand_duty[%0d]: got %0d required %0d (en=%0d dac=%0d vol=%0d)",
                         p, h, exp_duty, en, dac, vol);
            end
            checks++;
            if (b !== exp_busy) begin
                errors++;
                $display("FAIL rand_busy[%0d]: got %b required %b", p, b, exp_busy);
            end
            checks++;
            if (e !== 1'b0) begin
                errors++;
                $display("FAIL rand_last_cycle[%0d]: got %b required 0", p, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_volume();
        test_extremes();
        test_fade_out();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
